rou_initiator: RTL and testbench

Client-side endpoint of the rou message bus. It turns simple local read and write requests into rou request messages and drives them into one switch input port. It accepts rou response messages from the paired switch output port and retires them back to the client by tag. It sits between a local master and a rou switch port pair, and holds up to MAXOUT transactions in flight.

---
 rtl/rou_initiator.sv | 186 ++++++++++++++++++
 tb/tb_rou_initiator.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rou_initiator.sv
// rou bus client endpoint: turns local read/write requests into rou request
// messages, tracks outstanding tags, and retires rou responses back by tag.
module rou_initiator #(
    parameter int DWID   = 128,
    parameter int AWID   = 32,
    parameter int TWID   = 5,
    parameter int BWID   = (DWID == 512) ? 6 : (DWID == 256) ? 5 :
                           (DWID == 128) ? 4 : (DWID == 64) ? 3 : 2,
    parameter int WID    = 2 + DWID + AWID + BWID + TWID,
    parameter int MAXOUT = 8,
    localparam int CW    = $clog2(MAXOUT) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [AWID-1:0] req_addr,
    input  logic [DWID-1:0] req_data,
    input  logic [BWID-1:0] req_bytes,
    output logic [TWID-1:0] req_tag,
    output logic [WID-1:0]  rou_out,
    output logic            rou_out_seen,
    input  logic [2:0]      ack_out,
    input  logic [WID-1:0]  rou_in,
    input  logic            rou_in_seen,
    output logic [2:0]      ack_in,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [TWID-1:0] resp_tag,
    output logic            resp_write,
    output logic [DWID-1:0] resp_data,
    output logic [CW-1:0]   outstanding,
    output logic            err_unexpected
);

    localparam int TAG_LO = 2;
    localparam int BYT_LO = TAG_LO + TWID;
    localparam int ADR_LO = BYT_LO + BWID;
    localparam int DAT_LO = ADR_LO + AWID;

    function automatic logic [CW-1:0] popcount(input logic [MAXOUT-1:0] v);
        logic [CW-1:0] cnt;
        cnt = {CW{1'b0}};
        for (int i = 0; i < MAXOUT; i++) begin
            cnt = cnt + CW'(v[i]);
        end
        return cnt;
    endfunction

    logic              tx_valid_r;
    logic [WID-1:0]    tx_msg_r;
    logic [MAXOUT-1:0] busy_r;
    logic [MAXOUT-1:0] type_r;
    logic              rx_valid_r;
    logic [TWID-1:0]   rx_tag_r;
    logic              rx_write_r;
    logic [DWID-1:0]   rx_data_r;
    logic              err_r;

    logic              free_found_s;
    logic [TWID-1:0]   free_tag_s;
    logic              accept_s;
    logic [1:0]        in_kind_s;
    logic [TWID-1:0]   in_tag_s;
    logic              take_s;
    logic              hit_s;
    logic              hit_write_s;
    logic              retire_s;
    logic              bogus_s;
    logic [MAXOUT-1:0] set_mask_s;
    logic [MAXOUT-1:0] clr_mask_s;

    // Lowest free tag from the start-of-cycle bitmap (downward scan leaves the lowest).
    always_comb begin
        free_found_s = 1'b0;
        free_tag_s   = {TWID{1'b0}};
        for (int i = MAXOUT - 1; i >= 0; i--) begin
            if (!busy_r[i]) begin
                free_found_s = 1'b1;
                free_tag_s   = TWID'(i);
            end else begin
                free_found_s = free_found_s;
            end
        end
    end

    // Request handshake and incoming message classification.
    always_comb begin
        req_ready   = (!tx_valid_r || ack_out[0]) && free_found_s;
        accept_s    = req_valid && req_ready;
        in_kind_s   = rou_in[1:0];
        in_tag_s    = rou_in[TAG_LO +: TWID];
        take_s      = (in_kind_s != 2'd0) && (!rx_valid_r || resp_ready);
        hit_s       = 1'b0;
        hit_write_s = 1'b0;
        for (int i = 0; i < MAXOUT; i++) begin
            if (in_tag_s == TWID'(i)) begin
                hit_s       = busy_r[i];
                hit_write_s = type_r[i];
            end else begin
                hit_s = hit_s;
            end
        end
        retire_s = take_s && (in_kind_s == 2'd3) && hit_s;
        bogus_s  = take_s && !retire_s;
    end

    // One-hot masks for tag allocation and retirement.
    always_comb begin
        set_mask_s = {MAXOUT{1'b0}};
        clr_mask_s = {MAXOUT{1'b0}};
        for (int i = 0; i < MAXOUT; i++) begin
            set_mask_s[i] = accept_s && (free_tag_s == TWID'(i));
            clr_mask_s[i] = retire_s && (in_tag_s == TWID'(i));
        end
    end

    // TX register: load on accept, clear after transfer, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_valid_r <= 1'b0;
            tx_msg_r   <= {WID{1'b0}};
        end else if (accept_s) begin
            tx_valid_r <= 1'b1;
            tx_msg_r   <= {(req_write ? req_data : {DWID{1'b0}}), req_addr, req_bytes,
                           free_tag_s, (req_write ? 2'd1 : 2'd2)};
        end else if (tx_valid_r && ack_out[0]) begin
            tx_valid_r <= 1'b0;
            tx_msg_r   <= {WID{1'b0}};
        end else begin
            tx_valid_r <= tx_valid_r;
            tx_msg_r   <= tx_msg_r;
        end
    end

    // Tag pool and per-tag request type.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= {MAXOUT{1'b0}};
            type_r <= {MAXOUT{1'b0}};
        end else begin
            busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
            type_r <= (type_r & ~set_mask_s) | (req_write ? set_mask_s : {MAXOUT{1'b0}});
        end
    end

    // RX register and sticky error flag; dropped messages leave RX untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_r <= 1'b0;
            rx_tag_r   <= {TWID{1'b0}};
            rx_write_r <= 1'b0;
            rx_data_r  <= {DWID{1'b0}};
            err_r      <= 1'b0;
        end else begin
            if (retire_s) begin
                rx_valid_r <= 1'b1;
                rx_tag_r   <= in_tag_s;
                rx_write_r <= hit_write_s;
                rx_data_r  <= hit_write_s ? {DWID{1'b0}} : rou_in[DAT_LO +: DWID];
            end else if (resp_ready) begin
                rx_valid_r <= 1'b0;
            end else begin
                rx_valid_r <= rx_valid_r;
            end
            if (bogus_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign req_tag        = free_tag_s;
    assign rou_out        = tx_msg_r;
    assign rou_out_seen   = 1'b0;
    assign ack_in         = {2'b00, take_s};
    assign resp_valid     = rx_valid_r;
    assign resp_tag       = rx_tag_r;
    assign resp_write     = rx_write_r;
    assign resp_data      = rx_data_r;
    assign outstanding    = popcount(busy_r);
    assign err_unexpected = err_r;

endmodule

// File: tb/tb_rou_initiator.sv
// Randomized and directed bench for rou_initiator against a cycle-level
// behavioural model built from tag arrays and message fields.
module tb_rou_initiator;

    localparam int DWID   = 128;
    localparam int AWID   = 32;
    localparam int TWID   = 5;
    localparam int BWID   = 4;
    localparam int WID    = 2 + DWID + AWID + BWID + TWID;
    localparam int MAXOUT = 8;
    localparam int CW     = $clog2(MAXOUT) + 1;
    localparam int TAG_LO = 2;
    localparam int BYT_LO = TAG_LO + TWID;
    localparam int ADR_LO = BYT_LO + BWID;
    localparam int DAT_LO = ADR_LO + AWID;

    logic            clk;
    logic            rst_n;
    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [AWID-1:0] req_addr;
    logic [DWID-1:0] req_data;
    logic [BWID-1:0] req_bytes;
    logic [TWID-1:0] req_tag;
    logic [WID-1:0]  rou_out;
    logic            rou_out_seen;
    logic [2:0]      ack_out;
    logic [WID-1:0]  rou_in;
    logic            rou_in_seen;
    logic [2:0]      ack_in;
    logic            resp_valid;
    logic            resp_ready;
    logic [TWID-1:0] resp_tag;
    logic            resp_write;
    logic [DWID-1:0] resp_data;
    logic [CW-1:0]   outstanding;
    logic            err_unexpected;

    rou_initiator dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data), .req_bytes(req_bytes),
        .req_tag(req_tag), .rou_out(rou_out), .rou_out_seen(rou_out_seen),
        .ack_out(ack_out), .rou_in(rou_in), .rou_in_seen(rou_in_seen),
        .ack_in(ack_in), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_tag(resp_tag), .resp_write(resp_write), .resp_data(resp_data),
        .outstanding(outstanding), .err_unexpected(err_unexpected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit              m_busy [MAXOUT];
    bit              m_type [MAXOUT];
    bit              m_txv;
    logic [WID-1:0]  m_msg;
    bit              m_rxv;
    int              m_rx_tag;
    bit              m_rx_wr;
    logic [DWID-1:0] m_rx_data;
    bit              m_err;

    logic            obs_ready;
    logic [TWID-1:0] obs_tag;
    logic            obs_ack;
    logic [WID-1:0]  held;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < MAXOUT; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    function automatic int m_free();
        for (int i = 0; i < MAXOUT; i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < MAXOUT; i++) begin
            m_busy[i] = 1'b0;
            m_type[i] = 1'b0;
        end
        m_txv = 1'b0; m_msg = '0; m_rxv = 1'b0; m_rx_tag = 0;
        m_rx_wr = 1'b0; m_rx_data = '0; m_err = 1'b0;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0;
        req_bytes = '0; ack_out = 3'd1; rou_in = '0; rou_in_seen = 1'b0;
        resp_ready = 1'b1;
    endtask

    task automatic set_resp(input int t, input int kind);
        rou_in = '0;
        rou_in[1:0] = 2'(kind);
        rou_in[TAG_LO +: TWID] = TWID'(t);
        rou_in[DAT_LO +: DWID] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // One clock cycle: called at posedge+1 with inputs already applied.
    task automatic tick();
        bit exp_ready, exp_ack, acc;
        int ft, rt, kind;
        #4;
        exp_ready = (!m_txv || ack_out[0]) && (m_count() < MAXOUT);
        exp_ack   = (rou_in[1:0] != 2'd0) && (!m_rxv || resp_ready);
        obs_ready = req_ready; obs_tag = req_tag; obs_ack = ack_in[0];
        check_eq("req_ready", req_ready, exp_ready);
        if (exp_ready) check_eq("req_tag", req_tag, 256'(m_free()));
        check_eq("ack_in", ack_in, {2'b00, exp_ack});
        ft   = m_free();
        acc  = req_valid && exp_ready;
        kind = int'(rou_in[1:0]);
        rt   = int'(rou_in[TAG_LO +: TWID]);
        if (exp_ack && kind == 3 && rt < MAXOUT && m_busy[rt]) begin
            m_rxv = 1'b1; m_rx_tag = rt; m_rx_wr = m_type[rt];
            m_rx_data = m_type[rt] ? '0 : rou_in[DAT_LO +: DWID];
            m_busy[rt] = 1'b0;
        end else begin
            if (exp_ack) m_err = 1'b1;
            if (resp_ready) m_rxv = 1'b0;
        end
        if (acc) begin
            m_busy[ft] = 1'b1;
            m_type[ft] = req_write;
            m_txv = 1'b1;
            m_msg = {(req_write ? req_data : {DWID{1'b0}}), req_addr, req_bytes,
                     TWID'(ft), (req_write ? 2'd1 : 2'd2)};
        end else if (m_txv && ack_out[0]) begin
            m_txv = 1'b0;
            m_msg = '0;
        end
        @(posedge clk);
        #1;
        check_eq("rou_out", rou_out, m_msg);
        check_eq("rou_out_seen", rou_out_seen, 1'b0);
        check_eq("resp_valid", resp_valid, m_rxv);
        if (m_rxv) begin
            check_eq("resp_tag", resp_tag, 256'(m_rx_tag));
            check_eq("resp_write", resp_write, m_rx_wr);
            check_eq("resp_data", resp_data, m_rx_data);
        end
        check_eq("outstanding", outstanding, 256'(m_count()));
        check_eq("err_unexpected", err_unexpected, m_err);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_eq("rst_rou_out", rou_out, 0);
        check_eq("rst_ack_in", ack_in, 0);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_tag", resp_tag, 0);
        check_eq("rst_resp_data", resp_data, 0);
        check_eq("rst_resp_write", resp_write, 0);
        check_eq("rst_outstanding", outstanding, 0);
        check_eq("rst_err", err_unexpected, 0);
        check_eq("rst_req_ready", req_ready, 1);
    endtask

    task automatic issue_read(input int addr);
        req_valid = 1'b1; req_write = 1'b0; req_addr = AWID'(addr);
        req_bytes = 4'd8; req_data = '0;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;

        // Single write with immediate ack
        do_reset();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h100;
        req_data = 128'hA5; req_bytes = 4'd4; ack_out = 3'd1;
        tick();
        check_eq("t1_tag", obs_tag, 0);
        check_eq("t1_kind", rou_out[1:0], 1);
        check_eq("t1_msg_tag", rou_out[TAG_LO +: TWID], 0);
        check_eq("t1_addr", rou_out[ADR_LO +: AWID], 32'h100);
        check_eq("t1_data", rou_out[DAT_LO +: DWID], 128'hA5);
        check_eq("t1_bytes", rou_out[BYT_LO +: BWID], 4);
        req_valid = 1'b0;
        tick();
        check_eq("t1_idle", rou_out, 0);

        // Read held by backpressure for five cycles
        do_reset();
        ack_out = 3'd0;
        issue_read(32'h200);
        held = rou_out;
        check_eq("t2_kind", held[1:0], 2);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t2_hold", rou_out, held);
        end
        ack_out = 3'd1;
        tick();
        check_eq("t2_done", rou_out, 0);
        check_eq("t2_outstanding", outstanding, 1);

        // Fill pool, retire tag 3, reallocate it
        do_reset();
        for (int i = 0; i < MAXOUT; i++) begin
            issue_read(i * 16);
            check_eq("t3_tag", obs_tag, 256'(i));
        end
        set_resp(3, 3);
        tick();
        check_eq("t3_full", obs_ready, 0);
        check_eq("t3_rvalid", resp_valid, 1);
        check_eq("t3_rtag", resp_tag, 3);
        rou_in = '0;
        issue_read(32'h300);
        check_eq("t3_ready", obs_ready, 1);
        check_eq("t3_realloc", obs_tag, 3);

        // Unexpected response
        do_reset();
        set_resp(5, 3);
        tick();
        check_eq("t4_ack", obs_ack, 1);
        check_eq("t4_rvalid", resp_valid, 0);
        check_eq("t4_err", err_unexpected, 1);
        rou_in = '0;
        for (int i = 0; i < 3; i++) tick();
        check_eq("t4_sticky", err_unexpected, 1);

        // RX backpressure
        do_reset();
        issue_read(32'h10);
        issue_read(32'h20);
        resp_ready = 1'b0;
        set_resp(0, 3);
        tick();
        check_eq("t5_rtag0", resp_tag, 0);
        set_resp(1, 3);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq("t5_stall", obs_ack, 0);
        end
        resp_ready = 1'b1;
        tick();
        check_eq("t5_take", obs_ack, 1);
        check_eq("t5_rtag1", resp_tag, 1);
        rou_in = '0;
        tick();

        // Same-cycle retire and allocate
        do_reset();
        issue_read(32'h40);
        issue_read(32'h50);
        set_resp(0, 3);
        issue_read(32'h60);
        check_eq("t6_tag", obs_tag, 2);
        check_eq("t6_outstanding", outstanding, 2);
        rou_in = '0;

        // Reset mid-operation discards in-flight tags
        rst_n = 1'b0;
        #2;
        check_eq("t7_async", outstanding, 0);
        do_reset();
        set_resp(1, 3);
        tick();
        check_eq("t7_err", err_unexpected, 1);
        rou_in = '0;

        // Randomized traffic
        for (int blk = 0; blk < 6; blk++) begin
            do_reset();
            for (int c = 0; c < 500; c++) begin
                int busy_list[$];
                req_valid  = ($urandom_range(0, 3) != 0);
                req_write  = $urandom_range(0, 1) == 1;
                req_addr   = $urandom;
                req_data   = {$urandom, $urandom, $urandom, $urandom};
                req_bytes  = BWID'($urandom);
                ack_out    = 3'($urandom_range(0, 7));
                resp_ready = ($urandom_range(0, 2) != 0);
                for (int i = 0; i < MAXOUT; i++) if (m_busy[i]) busy_list.push_back(i);
                if (busy_list.size() > 0 && $urandom_range(0, 2) == 0)
                    set_resp(busy_list[$urandom_range(0, busy_list.size() - 1)], 3);
                else if ($urandom_range(0, 99) == 0)
                    set_resp($urandom_range(0, 31), $urandom_range(1, 3));
                else
                    rou_in = '0;
                tick();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
